// File: rtl/dynamic_to_static_7seg.sv
// Turns a scanned seven-segment bus into per-digit static segment/dp drives with PWM dimming.
// Optional SEG7_STALE_BLANK_EN: blank any digit not refreshed within stale_cycles.
module dynamic_to_static_7seg #(
    parameter int w_digit        = 8,
    parameter int min_hold       = 1,
    parameter int pwm_bits       = 4,
    parameter int stale_cycles   = 50_000_000,
    parameter bit seg_active_low = 1'b1,
    parameter bit dp_active_low  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             abcdefgh,
    input  logic [w_digit-1:0]     digit,
    input  logic [pwm_bits-1:0]    brightness,
    output logic [w_digit*7-1:0]   seg,
    output logic [w_digit-1:0]     dp
);

    localparam int                HOLD_W   = $clog2(min_hold + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(min_hold - 1);

    if (min_hold < 1 || pwm_bits < 1 || stale_cycles < 1) begin : g_bad_cfg
        $error("dynamic_to_static_7seg: min_hold, pwm_bits and stale_cycles must be >= 1");
    end

    logic [pwm_bits-1:0] r_pwm_cnt;
    logic                w_lit;

    // Input pattern is a..g in bits 7..1; output packs a..g into bits 0..6.
    function automatic logic [6:0] drive_seg(input logic [7:0] p, input logic on);
        logic [6:0] s;
        for (int k = 0; k < 7; k++) begin
            s[k] = (on & p[7-k]) ^ seg_active_low;
        end
        return s;
    endfunction

    function automatic logic drive_dp(input logic [7:0] p, input logic on);
        return (on & p[0]) ^ dp_active_low;
    endfunction

    assign w_lit = (brightness == '1) || (r_pwm_cnt < brightness);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < w_digit; i++) begin : g_dig
        logic [7:0]        r_pat;
        logic [HOLD_W-1:0] r_hold;
        logic [6:0]        r_seg;
        logic              r_dp;
        logic              w_cap;
        logic              w_show;

        assign w_cap = digit[i] && (r_hold == HOLD_MAX);

`ifdef SEG7_STALE_BLANK_EN
        localparam int               AGE_W   = $clog2(stale_cycles + 1);
        localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(stale_cycles);

        logic [AGE_W-1:0] r_age;
        logic [AGE_W-1:0] w_age_nxt;

        always_comb begin
            w_age_nxt = r_age;
            if (w_cap) begin
                w_age_nxt = '0;
            end else if (r_age != AGE_MAX) begin
                w_age_nxt = r_age + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_age <= '0;
            end else begin
                r_age <= w_age_nxt;
            end
        end

        // Mask on both sides of the edge so the blank lines up with the registered output.
        assign w_show = w_lit && (r_age != AGE_MAX) && (w_age_nxt != AGE_MAX);
`else
        assign w_show = w_lit;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r_pat  <= '0;
                r_hold <= '0;
                r_seg  <= {7{seg_active_low}};
                r_dp   <= dp_active_low;
            end else begin
                if (!digit[i]) begin
                    r_hold <= '0;
                end else if (r_hold != HOLD_MAX) begin
                    r_hold <= r_hold + 1'b1;
                end
                if (w_cap) begin
                    r_pat <= abcdefgh;
                end
                r_seg <= drive_seg(r_pat, w_show);
                r_dp  <= drive_dp(r_pat, w_show);
            end
        end

        assign seg[7*i +: 7] = r_seg;
        assign dp[i]         = r_dp;
    end

endmodule

// File: tb/tb_dynamic_to_static_7seg.sv
// Scoreboard bench for dynamic_to_static_7seg: min_hold=1 and min_hold=3 instances,
// plus a stale-blank instance when SEG7_STALE_BLANK_EN is defined.
module tb_dynamic_to_static_7seg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  abc;
    logic [3:0]  bright;
    logic [7:0]  digit_a, digit_b;
    logic [55:0] seg_a, seg_b;
    logic [7:0]  dp_a, dp_b;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [55:0] UNLIT = {56{1'b1}};

    typedef struct {
        int          cyc;
        int          unit;
        string       tag;
        logic [55:0] seg;
        logic [7:0]  dp;
    } exp_t;

    exp_t sb[$];

    dynamic_to_static_7seg #(.w_digit(8), .min_hold(1), .pwm_bits(4)) u_dut_a (
        .clk(clk), .rst(rst), .abcdefgh(abc), .digit(digit_a),
        .brightness(bright), .seg(seg_a), .dp(dp_a)
    );

    dynamic_to_static_7seg #(.w_digit(8), .min_hold(3), .pwm_bits(4)) u_dut_b (
        .clk(clk), .rst(rst), .abcdefgh(abc), .digit(digit_b),
        .brightness(bright), .seg(seg_b), .dp(dp_b)
    );

`ifdef SEG7_STALE_BLANK_EN
    logic [7:0]  digit_c;
    logic [55:0] seg_c;
    logic [7:0]  dp_c;

    dynamic_to_static_7seg #(.w_digit(8), .min_hold(1), .pwm_bits(4), .stale_cycles(10)) u_dut_c (
        .clk(clk), .rst(rst), .abcdefgh(abc), .digit(digit_c),
        .brightness(bright), .seg(seg_c), .dp(dp_c)
    );
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_at(input int c, input int unit, input string tag,
                             input logic [55:0] s, input logic [7:0] d);
        exp_t e;
        e.cyc  = c;
        e.unit = unit;
        e.tag  = tag;
        e.seg  = s;
        e.dp   = d;
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [55:0] put(input logic [55:0] base, input int idx, input logic [6:0] v);
        logic [55:0] r;
        r = base;
        r[7*idx +: 7] = v;
        return r;
    endfunction

    always @(negedge clk) begin
        logic [63:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].unit)
                    0:       act = {seg_a, dp_a};
                    1:       act = {seg_b, dp_b};
`ifdef SEG7_STALE_BLANK_EN
                    default: act = {seg_c, dp_c};
`else
                    default: act = '0;
`endif
                endcase
                check_eq(sb[i].tag, act, {sb[i].seg, sb[i].dp});
                sb.delete(i);
            end
        end
    end

    initial begin
        logic [55:0] e_cap, e_full, e_hold, e_cur, e_sim;
        int n_on, n_off;

        rst = 1'b1; abc = 8'h00; bright = 4'hF; digit_a = 8'h00; digit_b = 8'h00;
`ifdef SEG7_STALE_BLANK_EN
        digit_c = 8'h00;
`endif
        expect_at(1,   0, "rst_a",  UNLIT, 8'h00);
        expect_at(1,   1, "rst_b",  UNLIT, 8'h00);
        expect_at(2,   0, "rst_a2", UNLIT, 8'h00);
        expect_at(50,  0, "idle_a", UNLIT, 8'h00);
        expect_at(101, 0, "idle_a", UNLIT, 8'h00);
        expect_at(101, 1, "idle_b", UNLIT, 8'h00);
        goto(2);
        rst = 1'b0;

        // single capture, full brightness
        goto(110);
        digit_a = 8'h04; abc = 8'b1111_1101;
        e_cap = put(UNLIT, 2, 7'b1000000);
        expect_at(111, 0, "cap_pre",  UNLIT, 8'h00);
        expect_at(112, 0, "cap_vis",  e_cap, 8'h04);
        expect_at(130, 0, "cap_keep", e_cap, 8'h04);
        goto(111);
        digit_a = 8'h00; abc = 8'h00;

        // PWM duty
        goto(140);
        digit_a = 8'h01; abc = 8'hFE;
        e_full = put(e_cap, 0, 7'h00);
        expect_at(142, 0, "pwm_full", e_full, 8'h04);
        goto(141);
        digit_a = 8'h00;
        goto(150);
        bright = 4'd4;
        goto(160);
        n_on = 0; n_off = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (seg_a[6:0] == 7'h00) n_on++;
            else if (seg_a[6:0] == 7'h7F) n_off++;
        end
        check_eq("pwm4_on",  n_on,  4);
        check_eq("pwm4_off", n_off, 12);
        goto(180);
        bright = 4'd0;
        expect_at(181, 0, "pwm0_a", UNLIT, 8'h00);
        expect_at(188, 0, "pwm0_b", UNLIT, 8'h00);
        expect_at(196, 0, "pwm0_c", UNLIT, 8'h00);

        // hold filter with a dropout on the min_hold=3 instance
        goto(197);
        bright = 4'hF; abc = 8'h60; digit_b = 8'h01;
        e_hold = put(UNLIT, 0, 7'b1111001);
        expect_at(200, 1, "hold_drop", UNLIT,  8'h00);
        expect_at(203, 1, "hold_pre",  UNLIT,  8'h00);
        expect_at(204, 1, "hold_vis",  e_hold, 8'h00);
        expect_at(210, 1, "hold_keep", e_hold, 8'h00);
        goto(199);
        digit_b = 8'h00;
        goto(200);
        digit_b = 8'h01;
        goto(203);
        digit_b = 8'h00;

        // captured data is the last strobe cycle's pattern
        goto(220);
        digit_b = 8'h02; abc = 8'h60;
        e_cur = put(e_hold, 1, 7'b0100100);
        expect_at(223, 1, "cur_pre", e_hold, 8'h00);
        expect_at(224, 1, "cur_vis", e_cur,  8'h00);
        goto(222);
        abc = 8'hDA;
        goto(223);
        digit_b = 8'h00; abc = 8'h00;

        // all strobes at once
        goto(240);
        digit_a = 8'hFF; abc = 8'hB6;
        e_sim = {8{7'b0010010}};
        expect_at(242, 0, "simul",      e_sim, 8'h00);
        expect_at(245, 0, "simul_keep", e_sim, 8'h00);
        goto(241);
        digit_a = 8'h00;

        // reset mid-scan clears patterns and partial hold counts
        goto(250);
        digit_a = 8'h01; digit_b = 8'h01; abc = 8'hFE;
        expect_at(252, 0, "pre_rst_a", put(e_sim, 0, 7'h00), 8'h00);
        expect_at(252, 1, "pre_rst_b", e_cur, 8'h00);
        expect_at(253, 0, "rst_mid_a", UNLIT, 8'h00);
        expect_at(253, 1, "rst_mid_b", UNLIT, 8'h00);
        expect_at(255, 1, "hold_clr",  UNLIT, 8'h00);
        expect_at(257, 1, "hold_clr2", UNLIT, 8'h00);
        expect_at(260, 0, "rst_keep",  UNLIT, 8'h00);
        goto(252);
        rst = 1'b1; digit_a = 8'h00;
        goto(253);
        rst = 1'b0;
        goto(255);
        digit_b = 8'h00;

`ifdef SEG7_STALE_BLANK_EN
        goto(305);
        digit_c = 8'h02; abc = 8'hFE;
        expect_at(306, 2, "stale_pre",   UNLIT, 8'h00);
        expect_at(307, 2, "stale_lit",   put(UNLIT, 1, 7'h00), 8'h00);
        expect_at(315, 2, "stale_last",  put(UNLIT, 1, 7'h00), 8'h00);
        expect_at(316, 2, "stale_blank", UNLIT, 8'h00);
        expect_at(325, 2, "stale_hold",  UNLIT, 8'h00);
        expect_at(331, 2, "relit_pre",   UNLIT, 8'h00);
        expect_at(332, 2, "relit",       put(UNLIT, 1, 7'h00), 8'h00);
        goto(306);
        digit_c = 8'h00;
        goto(330);
        digit_c = 8'h02;
        goto(331);
        digit_c = 8'h00;
`endif

        goto(345);
        check_eq("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
